// File: rtl/sram_like_resp.sv
`default_nettype none
// ============================================================================
// Module   : sram_like_resp
// Purpose  : Responder end of the SRAM-like bus, backed by a word-organised
//            on-chip memory. Accepted requests complete in order with one
//            data_ok strobe each, LATENCY cycles after the address handshake.
// Options  : define SRAM_RESP_STALL_EN to gate addr_ok with a 16-bit LFSR
//            for pseudo-random address back-pressure.
// Revision : 1.0 - initial release
// ============================================================================
module sram_like_resp #(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2,
    parameter int OUTSTANDING = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        wr,
    input  logic [1:0]  size,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        addr_ok,
    output logic        data_ok,
    output logic [31:0] rdata
);

    localparam int             AW        = $clog2(DEPTH_WORDS);
    localparam int             PW        = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
    localparam logic [3:0]     LAT_AGE   = 4'(LATENCY);
    localparam logic [2:0]     SLOTS     = 3'(OUTSTANDING);
    localparam logic [PW-1:0]  LAST_SLOT = PW'(OUTSTANDING - 1);

    // Backing store; never reset so contents survive a mid-run reset.
    logic [31:0]            mem [DEPTH_WORDS];

    // Completion queue: data captured at accept plus an age counter.
    logic [31:0]            q_data  [OUTSTANDING];
    logic [3:0]             q_age   [OUTSTANDING];
    logic [OUTSTANDING-1:0] q_valid;
    logic [PW-1:0]          head;
    logic [PW-1:0]          tail;
    logic [2:0]             count;

    logic [AW-1:0]          word_idx;
    logic [31:0]            cur_word;
    logic [31:0]            merged;
    logic [3:0]             byte_en;
    logic                   room;
    logic                   accept;
    logic                   pop;
    logic                   unused_addr_bits;

    // Upper address bits alias onto the array.
    assign word_idx         = addr[AW+1:2];
    assign unused_addr_bits = ^addr[31:AW+2];
    assign cur_word         = mem[word_idx];

    // A pop in the same cycle does not free a slot: use registered count only.
    assign room = (count < SLOTS);

`ifdef SRAM_RESP_STALL_EN
    logic [15:0] lfsr;

    // Fibonacci LFSR, taps 16,14,13,11, advancing every cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr <= 16'hACE1;
        end else begin
            lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
        end
    end

    assign addr_ok = req && room && lfsr[0];
`else
    assign addr_ok = req && room;
`endif

    assign accept = addr_ok;
    assign pop    = q_valid[head] && (q_age[head] == LAT_AGE);

    function automatic logic [PW-1:0] next_slot(input logic [PW-1:0] p);
        return (p == LAST_SLOT) ? '0 : p + 1'b1;
    endfunction

    // Byte enables from size and lane; misaligned half/word writes update nothing.
    always_comb begin
        byte_en = 4'b0000;
        case (size)
            2'b00:   byte_en = 4'b0001 << addr[1:0];
            2'b01:   if (!addr[0]) byte_en = addr[1] ? 4'b1100 : 4'b0011;
            default: if (addr[1:0] == 2'b00) byte_en = 4'b1111;
        endcase
    end

    // Merge write lanes over the current word.
    always_comb begin
        merged = cur_word;
        for (int i = 0; i < 4; i++) begin
            if (byte_en[i]) merged[8*i +: 8] = wdata[8*i +: 8];
        end
    end

    // Memory write at the accept edge.
    always_ff @(posedge clk) begin
        if (accept && wr) begin
            mem[word_idx] <= merged;
        end
    end

    // Completion queue: age entries, pop the ready head, push new accepts.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head    <= '0;
            tail    <= '0;
            count   <= '0;
            q_valid <= '0;
            data_ok <= 1'b0;
            rdata   <= '0;
            for (int i = 0; i < OUTSTANDING; i++) begin
                q_age[i]  <= '0;
                q_data[i] <= '0;
            end
        end else begin
            for (int i = 0; i < OUTSTANDING; i++) begin
                if (q_valid[i] && (q_age[i] != LAT_AGE)) begin
                    q_age[i] <= q_age[i] + 4'd1;
                end
            end

            data_ok <= pop;
            if (pop) begin
                rdata         <= q_data[head];
                q_valid[head] <= 1'b0;
                head          <= next_slot(head);
            end

            // Age starts at 1 so the entry is ready LATENCY edges after accept.
            if (accept) begin
                q_data[tail]  <= cur_word;
                q_age[tail]   <= 4'd1;
                q_valid[tail] <= 1'b1;
                tail          <= next_slot(tail);
            end

            case ({accept, pop})
                2'b10:   count <= count + 3'd1;
                2'b01:   count <= count - 3'd1;
                default: count <= count;
            endcase
        end
    end

endmodule
`default_nettype wire
